// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared item, price, coin and state definitions for the dispense controller
package vend_pkg;

  localparam logic [3:0] ITEM_SNACK  = 4'b1000;
  localparam logic [3:0] ITEM_COFFEE = 4'b0100;
  localparam logic [3:0] ITEM_DRINK  = 4'b0010;
  localparam logic [3:0] ITEM_CANDY  = 4'b0001;

  localparam logic [2:0] PRICE_LO = 3'd3;
  localparam logic [2:0] PRICE_HI = 3'd4;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b01;
  localparam logic [1:0] COIN_20   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_WAIT_DROP,
    ST_PAY,
    ST_PAY_WAIT,
    ST_DONE,
    ST_FAULT
  } state_t;

  function automatic logic item_valid(input logic [3:0] item);
    return (item == ITEM_SNACK) || (item == ITEM_COFFEE) ||
           (item == ITEM_DRINK) || (item == ITEM_CANDY);
  endfunction

  function automatic logic [2:0] item_price(input logic [3:0] item);
    case (item)
      ITEM_SNACK, ITEM_CANDY:  return PRICE_LO;
      ITEM_COFFEE, ITEM_DRINK: return PRICE_HI;
      default:                 return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// rtl/vend_timeout_ctr.sv - loadable down-counter; expired is high while the count sits at zero
module vend_timeout_ctr #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - motor/drop/hopper dispense sequencer; VEND_CTRL_COIN20_EN enables 20-coin payout
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 16,
  parameter int DROP_TIMEOUT   = 1024,
  parameter int HOPPER_TIMEOUT = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_item,
  input  logic [2:0] req_credit,
  input  logic       req_refund,
  output logic [3:0] motor,
  input  logic       drop_sense,
  output logic [1:0] hopper_cmd,
  input  logic       hopper_ack,
  output logic       done,
  output logic       jam,
  output logic [2:0] change_out,
  output logic       fault
);

  localparam int TMAX_A = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMAX   = (TMAX_A > HOPPER_TIMEOUT) ? TMAX_A : HOPPER_TIMEOUT;
  localparam int TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

  state_t      state;
  state_t      next_state;
  logic [3:0]  item_q;
  logic [2:0]  credit_q;
  logic [2:0]  remaining;
  logic [2:0]  paid;
  logic        jam_flag;
  logic        go_motor;
  logic        tmr_load;
  logic [TW-1:0] tmr_value;
  logic        tmr_expired;
  logic [1:0]  coin_next;
  logic [2:0]  coin_val;

  // Only a valid, fully paid, non-cancelled request runs the motor; anything else is a refund.
  assign go_motor = !req_refund && item_valid(req_item) &&
                    (req_credit >= item_price(req_item));

`ifdef VEND_CTRL_COIN20_EN
  logic [1:0] coin_q;
  assign coin_next = (remaining >= 3'd2) ? COIN_20 : COIN_10;
  assign coin_val  = (coin_q == COIN_20) ? 3'd2 : 3'd1;
`else
  assign coin_next = COIN_10;
  assign coin_val  = 3'd1;
`endif

  vend_timeout_ctr #(
    .WIDTH(TW)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    hopper_cmd = COIN_NONE;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (go_motor) begin
            next_state = ST_MOTOR;
            tmr_load   = 1'b1;
            tmr_value  = TW'(MOTOR_CYCLES - 1);
          end else begin
            next_state = ST_PAY;
          end
        end
      end
      ST_MOTOR: begin
        if (tmr_expired) begin
          next_state = ST_WAIT_DROP;
          tmr_load   = 1'b1;
          tmr_value  = TW'(DROP_TIMEOUT - 1);
        end
      end
      ST_WAIT_DROP: begin
        if (drop_sense || tmr_expired) begin
          next_state = ST_PAY;
        end
      end
      ST_PAY: begin
        if (remaining == 3'd0) begin
          next_state = ST_DONE;
        end else begin
          hopper_cmd = coin_next;
          next_state = ST_PAY_WAIT;
          tmr_load   = 1'b1;
          tmr_value  = TW'(HOPPER_TIMEOUT - 1);
        end
      end
      ST_PAY_WAIT: begin
        if (hopper_ack) begin
          next_state = ST_PAY;
        end else if (tmr_expired) begin
          next_state = ST_FAULT;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      item_q     <= '0;
      credit_q   <= '0;
      remaining  <= '0;
      paid       <= '0;
      jam_flag   <= 1'b0;
      change_out <= '0;
`ifdef VEND_CTRL_COIN20_EN
      coin_q     <= COIN_NONE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            item_q    <= req_item;
            credit_q  <= req_credit;
            paid      <= '0;
            jam_flag  <= 1'b0;
            remaining <= go_motor ? (req_credit - item_price(req_item)) : req_credit;
          end
        end
        ST_WAIT_DROP: begin
          // A jam refunds the whole credit; a simultaneous drop keeps the sale.
          if (!drop_sense && tmr_expired) begin
            remaining <= credit_q;
            jam_flag  <= 1'b1;
          end
        end
        ST_PAY: begin
          if (remaining == 3'd0) begin
            change_out <= paid;
          end
`ifdef VEND_CTRL_COIN20_EN
          else begin
            coin_q <= coin_next;
          end
`endif
        end
        ST_PAY_WAIT: begin
          if (hopper_ack) begin
            remaining <= remaining - coin_val;
            paid      <= paid + coin_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign motor     = (state == ST_MOTOR) ? item_q : 4'b0000;
  assign done      = (state == ST_DONE);
  assign jam       = (state == ST_DONE) && jam_flag;
  assign fault     = (state == ST_FAULT);

endmodule
